icache_tag1: RTL and testbench
==============================

# icache_tag1

- Instruction-cache tag store: 256-entry × 21-bit simple dual-port RAM.
- One write port on `wr_clk`, one read port on `rd_clk`; the two clocks may be asynchronous to each other.
- Sits between the I-cache controller's tag-update path (write) and its tag-lookup path (read).
- Reads are synchronous with one cycle of latency and no extra output register; the device-level global reset (GSR/GRS net) is held inactive and has no functional effect.

## Interface
Parameters (fixed in this instance):
- ADDR_WIDTH, 8, address width of both ports (depth 256)
- DATA_WIDTH, 21, tag word width on both ports (same width, no byte enables)

Ports:
- wr_clk  in  1  write-port clock
- tb_wr_rst  in  1  write-port reset; asynchronous, active-high; clock wr_clk
- rd_clk  in  1  read-port clock
- rd_rst  in  1  read-port reset, asynchronous, active-high
- wr_en  in  1  write enable, sampled on rising wr_clk
- wr_addr  in  8  write address
- wr_data  in  21  write data
- rd_addr  in  8  read address, sampled on every rising rd_clk (no read enable)
- rd_data  out  21  read data

## Operation
- Storage: mem[0..255] of 21 bits; powers up all-zero; no init file; contents never cleared by any reset.
- Write: on rising wr_clk, when wr_en=1 and tb_wr_rst=0, mem[wr_addr] <= wr_data. Whenever wr_en=0 or tb_wr_rst=1, no write occurs.
- Read:
  - On rising rd_clk with rd_rst=0, rd_data <= mem[rd_addr], unconditionally every cycle.
  - No clock enable, no output-enable, no address strobe.
- Read-port reset: rd_rst=1 asynchronously forces rd_data to 0 and holds it there while asserted.
- Write-port reset: tb_wr_rst=1 only blocks writes; it does not affect rd_data.
- Address wrap: addresses are exactly 8 bits, so there is no out-of-range case.
- Same-address collision (write and read of one address in overlapping edges):
  - rd_data returns the old contents (read-first).
  - The new value is visible from the next read edge.
  - With asynchronous clocks, the collision result is undefined only within that single overlapping edge pair.

## Timing
- Reset values: rd_data = 21'h0 while rd_rst is high and until the first rd_clk rising edge after release.
- Write latency: data written at edge N is readable by a read sampled at any rd_clk edge strictly after edge N.
- Read latency: 1 rd_clk cycle. The address present at rising edge K appears on rd_data just after edge K and is stable until edge K+1.
- Throughput: one write per wr_clk cycle and one read per rd_clk cycle, with full back-to-back operation on both ports.
- Reset mid-operation:
  - Asserting rd_rst mid-burst zeroes the output immediately; the next post-release edge resumes normal reads.
  - Asserting tb_wr_rst mid-burst drops the writes of those cycles; earlier writes are retained.

## Test plan
- Reset: hold both resets for 200 ns -> rd_data = 0; after release with rd_addr=0, rd_data = 0 (power-up contents).
- Burst fill and readback:
  - Stimulus: write addresses 1..255 back-to-back with data 0x1FFFFF, 0x1FFFFE, … (address k ← 0x1FFFFF−(k−1)); then read addresses 1..255 back-to-back, 10 ns clocks.
  - Required response: each rd_data equals the matching value one rd_clk after its address; zero mismatches.
- Write gating: wr_en=0 with wr_data=0x0ABCDE at address 5 -> read of address 5 still returns 0x1FFFFB; address 0 remains 0.
- Write reset: assert tb_wr_rst while writing 0x155555 to address 10 -> read returns the previous value 0x1FFFF6; rd_data is unaffected during the reset.
- Read reset mid-stream: pulse rd_rst during a readback -> rd_data = 0 immediately; the first edge after release returns mem[rd_addr].
- Collision: same clock, write 0x000123 to address 7 while reading address 7 -> rd_data shows the old value 0x1FFFF9, and the next cycle shows 0x000123.

Source files
------------

// File: rtl/icache_tag1.sv
// Instruction-cache tag store: 256 x 21 simple dual-port RAM, independent write/read clocks.
// Synchronous read, one cycle of latency, read-first on same-address collisions.
module icache_tag1 #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 21
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write reset only gates the enable; storage is never cleared.
    always_ff @(posedge wr_clk) begin
        if (wr_en && !tb_wr_rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_icache_tag1.sv
// Directed self-checking bench for icache_tag1: reset, burst fill/readback, gating, resets, collision.
`timescale 1ns/1ps
module tb_icache_tag1;

    logic        wr_clk = 1'b0;
    logic        rd_clk = 1'b0;
    logic        tb_wr_rst;
    logic        rd_rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [20:0] wr_data;
    logic [7:0]  rd_addr;
    logic [20:0] rd_data;

    int unsigned checks = 0;
    int unsigned passes = 0;

    icache_tag1 #(.ADDR_WIDTH(8), .DATA_WIDTH(21)) dut (
        .wr_clk   (wr_clk),
        .tb_wr_rst(tb_wr_rst),
        .rd_clk   (rd_clk),
        .rd_rst   (rd_rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Both clocks share period and phase so the collision case is deterministic.
    always #5 wr_clk = ~wr_clk;
    always #5 rd_clk = ~rd_clk;

    task automatic check(input string tag, input logic [20:0] expected);
        checks++;
        assert (rd_data === expected) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, rd_data, expected);
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    function automatic logic [20:0] fill_val(input int unsigned k);
        return 21'h1FFFFF - 21'(k - 1);
    endfunction

    initial begin
        tb_wr_rst = 1'b1;
        rd_rst    = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;

        #200;
        check("reset_hold", 21'h0);
        tb_wr_rst = 1'b0;
        rd_rst    = 1'b0;
        #1;
        check("reset_release_before_edge", 21'h0);
        step();
        check("powerup_addr0", 21'h0);

        for (int unsigned k = 1; k <= 255; k++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(k);
            wr_data = fill_val(k);
            step();
        end
        wr_en = 1'b0;

        for (int unsigned k = 1; k <= 255; k++) begin
            rd_addr = 8'(k);
            step();
            check($sformatf("readback_%0d", k), fill_val(k));
        end

        wr_en   = 1'b0;
        wr_addr = 8'd5;
        wr_data = 21'h0ABCDE;
        rd_addr = 8'd5;
        step();
        step();
        check("gated_addr5", 21'h1FFFFB);
        rd_addr = 8'd0;
        step();
        check("gated_addr0", 21'h0);

        rd_addr = 8'd3;
        step();
        check("pre_wrrst_addr3", 21'h1FFFFD);
        tb_wr_rst = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 8'd10;
        wr_data   = 21'h155555;
        step();
        check("wrrst_rd_unaffected_1", 21'h1FFFFD);
        step();
        check("wrrst_rd_unaffected_2", 21'h1FFFFD);
        tb_wr_rst = 1'b0;
        wr_en     = 1'b0;
        rd_addr   = 8'd10;
        step();
        check("wrrst_dropped_addr10", 21'h1FFFF6);

        rd_addr = 8'd20;
        step();
        check("pre_rdrst_addr20", 21'h1FFFEC);
        rd_addr = 8'd21;
        #2;
        rd_rst = 1'b1;
        #1;
        check("rdrst_immediate", 21'h0);
        step();
        check("rdrst_held_over_edge", 21'h0);
        #2;
        rd_rst = 1'b0;
        #1;
        check("rdrst_released_before_edge", 21'h0);
        step();
        check("rdrst_resume_addr21", 21'h1FFFEB);

        rd_addr = 8'd7;
        wr_en   = 1'b1;
        wr_addr = 8'd7;
        wr_data = 21'h000123;
        step();
        check("collision_old", 21'h1FFFF9);
        wr_en = 1'b0;
        step();
        check("collision_new", 21'h000123);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
